// File: rtl/updown_seq_ctrl.sv
// updown_seq_ctrl: rate-selectable count-enable tick generator and direction sequencer for an 8-bit up/down counter.
// Build macro SEQ_DWELL_EN adds a dwell pause of DWELL_TICKS tick periods at each auto-mode turn point.
module updown_seq_ctrl #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned SLOW_HZ     = 2000,
    parameter int unsigned FAST_HZ     = 4000,
    parameter logic [7:0]  LIM_HI      = 8'hFF,
    parameter logic [7:0]  LIM_LO      = 8'h00,
    parameter int unsigned DWELL_TICKS = 4
) (
    input  logic       CLK50MHz,
    input  logic       RST,
    input  logic       S0,
    input  logic       S1,
    input  logic       AUTO,
    input  logic       START,
    input  logic       STOP,
    input  logic [7:0] CNT_Q,
    output logic       CNT_EN,
    output logic       CNT_UP,
    output logic       BUSY,
    output logic       AT_LIMIT
);

    localparam logic [23:0] DIV_SLOW_M1 = 24'(CLK_HZ / SLOW_HZ - 32'd1);
    localparam logic [23:0] DIV_FAST_M1 = 24'(CLK_HZ / FAST_HZ - 32'd1);

    if ((DWELL_TICKS < 32'd1) || (DWELL_TICKS > 32'd65536) ||
        (CLK_HZ / SLOW_HZ < 32'd2) || (CLK_HZ / FAST_HZ < 32'd2) ||
        (CLK_HZ / SLOW_HZ >= 32'd16777216) || (CLK_HZ / FAST_HZ >= 32'd16777216) ||
        (LIM_HI <= LIM_LO)) begin : g_param_check
        $error("updown_seq_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN_UP = 2'd1,
        ST_RUN_DN = 2'd2
`ifdef SEQ_DWELL_EN
        ,
        ST_DWELL  = 2'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] presc_q, presc_d;
    logic        s0_meta_q, s0_sync_q, s1_meta_q, s1_sync_q;
    logic        auto_q, auto_d;
    logic        chk_q, chk_d;
    logic        cnt_en_q, cnt_en_d;
    logic        cnt_up_q, cnt_up_d;
    logic        busy_q, busy_d;
    logic        at_limit_q, at_limit_d;
    logic [23:0] reload_s;
    logic        tick_s;
    logic        run_now_s, run_next_s;
`ifdef SEQ_DWELL_EN
    localparam logic [15:0] DWELL_M1 = 16'(DWELL_TICKS - 32'd1);
    logic [15:0] dwell_q, dwell_d;
`endif

    // Next-state, prescaler and output decode.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        auto_d     = auto_q;
        cnt_up_d   = cnt_up_q;
        at_limit_d = 1'b0;
        cnt_en_d   = 1'b0;
        tick_s     = 1'b0;
        reload_s   = s1_sync_q ? DIV_FAST_M1 : DIV_SLOW_M1;
`ifdef SEQ_DWELL_EN
        dwell_d    = dwell_q;
`endif

        // Rate select is only consulted at reload, so a running period is never cut short.
        if (state_q == ST_IDLE) begin
            presc_d = reload_s;
        end else if (presc_q == 24'd0) begin
            presc_d = reload_s;
            tick_s  = 1'b1;
        end else begin
            presc_d = presc_q - 24'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    auto_d = AUTO;
                    if (AUTO || s0_sync_q) begin
                        state_d  = ST_RUN_UP;
                        cnt_up_d = 1'b1;
                    end else begin
                        state_d  = ST_RUN_DN;
                        cnt_up_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN_UP, ST_RUN_DN: begin
                // chk_q marks the cycle after a tick, when CNT_Q already shows the new value.
                if (!chk_q) begin
                    state_d = state_q;
                end else if (!auto_q) begin
                    state_d  = s0_sync_q ? ST_RUN_UP : ST_RUN_DN;
                    cnt_up_d = s0_sync_q;
                end else if (((state_q == ST_RUN_UP) && (CNT_Q >= LIM_HI)) ||
                             ((state_q == ST_RUN_DN) && (CNT_Q <= LIM_LO))) begin
                    at_limit_d = 1'b1;
`ifdef SEQ_DWELL_EN
                    state_d    = ST_DWELL;
                    dwell_d    = DWELL_M1;
`else
                    state_d    = (state_q == ST_RUN_UP) ? ST_RUN_DN : ST_RUN_UP;
                    cnt_up_d   = (state_q != ST_RUN_UP);
`endif
                end else begin
                    state_d = state_q;
                end
            end
`ifdef SEQ_DWELL_EN
            ST_DWELL: begin
                if (!tick_s) begin
                    state_d = ST_DWELL;
                end else if (dwell_q == 16'd0) begin
                    state_d  = cnt_up_q ? ST_RUN_DN : ST_RUN_UP;
                    cnt_up_d = ~cnt_up_q;
                end else begin
                    dwell_d = dwell_q - 16'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (STOP) begin
            state_d    = ST_IDLE;
            at_limit_d = 1'b0;
        end else begin
            state_d = state_d;
        end

        // A tick is only issued when both this and the next state are running states.
        run_now_s  = (state_q == ST_RUN_UP) || (state_q == ST_RUN_DN);
        run_next_s = (state_d == ST_RUN_UP) || (state_d == ST_RUN_DN);
        cnt_en_d   = tick_s && run_now_s && run_next_s;
        chk_d      = cnt_en_q && !STOP;
        busy_d     = (state_d != ST_IDLE);
    end

    // State, prescaler, switch synchronisers and registered outputs.
    always_ff @(posedge CLK50MHz) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            presc_q    <= DIV_SLOW_M1;
            s0_meta_q  <= 1'b0;
            s0_sync_q  <= 1'b0;
            s1_meta_q  <= 1'b0;
            s1_sync_q  <= 1'b0;
            auto_q     <= 1'b0;
            chk_q      <= 1'b0;
            cnt_en_q   <= 1'b0;
            cnt_up_q   <= 1'b1;
            busy_q     <= 1'b0;
            at_limit_q <= 1'b0;
`ifdef SEQ_DWELL_EN
            dwell_q    <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            s0_meta_q  <= S0;
            s0_sync_q  <= s0_meta_q;
            s1_meta_q  <= S1;
            s1_sync_q  <= s1_meta_q;
            auto_q     <= auto_d;
            chk_q      <= chk_d;
            cnt_en_q   <= cnt_en_d;
            cnt_up_q   <= cnt_up_d;
            busy_q     <= busy_d;
            at_limit_q <= at_limit_d;
`ifdef SEQ_DWELL_EN
            dwell_q    <= dwell_d;
`endif
        end
    end

    assign CNT_EN   = cnt_en_q;
    assign CNT_UP   = cnt_up_q;
    assign BUSY     = busy_q;
    assign AT_LIMIT = at_limit_q;

endmodule
